// File: rtl/fifo_packer.sv
// Drains a registered-output scratchpad FIFO and packs PACK words into one
// wide beat with valid/ready; a short final beat is zero-padded and masked.
//
// state | meaning
// IDLE  | waiting for i_start
// FILL  | popping words into lanes for the current beat
// DRAIN | beat presented, waiting for i_ready
// DONE  | one-cycle o_done pulse
module fifo_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_start,
    input  logic [LEN_WIDTH-1:0]       i_len,
    output logic                       o_busy,
    output logic                       o_done,
    input  logic                       i_fifo_empty,
    output logic                       o_fifo_pop_en,
    input  logic [DATA_WIDTH-1:0]      i_fifo_pop_out,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [PACK*DATA_WIDTH-1:0] o_data,
    output logic [PACK-1:0]            o_lane_mask,
    output logic                       o_last
);

    localparam int CW = $clog2(PACK + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
    logic [CW-1:0]             issued_q, issued_d;
    logic [CW-1:0]             received_q, received_d;
    logic                      inflight_q, inflight_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic [PACK-1:0]           mask_q, mask_d;
    logic [PACK*DATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]      need;
    logic                      pop;

    assign need = (remaining_q < LEN_WIDTH'(PACK)) ? remaining_q : LEN_WIDTH'(PACK);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        received_d  = received_q;
        inflight_d  = 1'b0;
        valid_d     = valid_q;
        last_d      = last_q;
        mask_d      = mask_q;
        data_d      = data_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        remaining_d = i_len;
                        state_d     = S_FILL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL: begin
                pop        = !i_fifo_empty && (LEN_WIDTH'(issued_q) < need);
                inflight_d = pop;
                if (pop) issued_d = issued_q + 1'b1;
                // Pop data lands one cycle after the request, tracked by inflight_q.
                if (inflight_q) begin
                    for (int k = 0; k < PACK; k++) begin
                        if (received_q == CW'(k)) begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = i_fifo_pop_out;
                            mask_d[k] = 1'b1;
                        end
                    end
                    received_d = received_q + 1'b1;
                    if (LEN_WIDTH'(received_q) == need - 1'b1) begin
                        valid_d     = 1'b1;
                        last_d      = (remaining_q == need);
                        remaining_d = remaining_q - need;
                        state_d     = S_DRAIN;
                        for (int k = 0; k < PACK; k++) begin
                            if (LEN_WIDTH'(k) >= need) begin
                                data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                                mask_d[k] = 1'b0;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (valid_q && i_ready) begin
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    issued_d   = '0;
                    received_d = '0;
                    mask_d     = '0;
                    data_d     = '0;
                    state_d    = last_q ? S_DONE : S_FILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_clear) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            issued_d    = '0;
            received_d  = '0;
            inflight_d  = 1'b0;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            mask_d      = '0;
            data_d      = '0;
            pop         = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            inflight_q  <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            mask_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            inflight_q  <= inflight_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
        end
    end

    assign o_fifo_pop_en = pop;
    assign o_busy        = (state_q == S_FILL) || (state_q == S_DRAIN);
    assign o_done        = (state_q == S_DONE);
    assign o_valid       = valid_q;
    assign o_last        = last_q;
    assign o_lane_mask   = mask_q;
    assign o_data        = data_q;

endmodule

// File: doc/fifo_packer.md
Name: fifo_packer

Overview:
- Drains a scratchpad FIFO that has a registered 1-cycle pop output, an empty flag and pop/clear controls.
- Packs PACK consecutive DATA_WIDTH words into one wide operand for the PE array, using a valid/ready handshake.
- Transfer length is programmable per start. A partial final pack is zero-padded and flagged with o_last and o_lane_mask.

Parameters:
- DATA_WIDTH, 8: width of one FIFO word.
- PACK, 4: words per output beat (≥2).
- LEN_WIDTH, 16: width of the transfer-length field, in words.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous abort; returns to IDLE.
- i_start  in  1  start pulse; sampled in IDLE only.
- i_len  in  LEN_WIDTH  words to transfer; sampled with i_start.
- o_busy  out  1  high in FILL or DRAIN.
- o_done  out  1  1-cycle pulse after the final beat is accepted.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_pop_en  out  1  FIFO pop request.
- i_fifo_pop_out  in  DATA_WIDTH  FIFO pop data; valid the cycle after pop_en.
- o_valid  out  1  output beat valid.
- i_ready  in  1  consumer ready.
- o_data  out  PACK*DATA_WIDTH  packed beat; lane 0 in the LSBs and holds the first-popped word.
- o_lane_mask  out  PACK  bit k set when lane k holds real data.
- o_last  out  1  high on the final beat of a transfer.

Behaviour:
- Reset (i_rst high, async): state IDLE. All outputs 0, remaining count 0, in-flight pop flag cleared.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - i_start with i_len>0 loads remaining=i_len and goes to FILL.
  - i_start with i_len==0 goes to DONE (o_done pulse next cycle, no beat).
- FILL:
  - o_fifo_pop_en = !i_fifo_empty && issued < need, where need = min(PACK, remaining).
  - At most one pop per cycle; back-to-back pops allowed.
  - A 1-bit in-flight register marks that a pop was issued last cycle. That cycle, i_fifo_pop_out is written into lane[received], received increments and the matching mask bit is set.
  - The edge that captures lane need-1 also sets o_valid, sets o_last if remaining==need, subtracts need from remaining, zeroes lanes ≥ need, and moves to DRAIN.
- DRAIN:
  - o_data, o_lane_mask and o_last are held stable and o_fifo_pop_en=0 while o_valid && !i_ready.
  - On o_valid && i_ready: o_valid drops next cycle, issued/received reset, lanes cleared. Next state is DONE if o_last, else FILL.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- i_start is ignored outside IDLE.
- FIFO empty mid-pack: pops stall and partial lanes are held. There is no timeout.
- i_clear (priority over everything except reset), next cycle:
  - state IDLE; o_valid, o_last, o_lane_mask, o_busy, counters and in-flight flag all 0.
  - no o_done pulse.
  - pop data arriving the cycle after clear is discarded.
- Throughput: with a non-empty FIFO, one full beat per PACK+2 cycles when i_ready stays high.

Test Plan:
1. PACK=4; FIFO preloaded 0x11,0x22,0x33,0x44; i_start in cycle 0, i_len=4, i_ready=1.
   -> pop_en high cycles 1-4; o_valid high cycle 6 only; o_data=0x44332211, mask=4'b1111, o_last=1; o_done cycle 7.
2. i_len=6, FIFO holds 0x01..0x06.
   -> beat1 0x04030201, mask 1111, last=0; beat2 0x00000605, mask 0011, last=1; exactly 6 pops total.
3. i_ready=0 for 5 cycles after o_valid, then 1.
   -> o_data/mask/last stable throughout stall; no pops while stalled; beat accepted on the first ready cycle.
4. FIFO empty after 2 words, refilled 3 cycles later.
   -> pop_en low while empty; lanes 0-1 retained; final beat correct, with no duplicated or lost words.
5. i_clear asserted in FILL with a pop in flight.
   -> next cycle IDLE, all outputs 0, no o_done. A new i_start with i_len=4 then produces a correct beat.
6. i_len=0 start.
   -> o_done pulse one cycle later, no pops, o_valid never asserts.
7. Async i_rst mid-DRAIN.
   -> all outputs 0 immediately, without waiting for a clock edge.
